// File: rtl/riscv_pkg.sv
// Shared RV64I constants for the operand-fetch stage and the ALU behind it:
// opcodes, funct3 encodings, datapath width and the immediate sign-extender.
package riscv_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/operand_fetch_regfile.sv
// 32 x XLEN architectural register file: two asynchronous reads with
// writeback bypass, one synchronous write, x0 hardwired to zero.
module regfile
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];

    // Same-cycle writeback is forwarded so a stalled reader can issue on the clearing edge.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        logic [XLEN-1:0] val;
        if (addr == 5'd0) begin
            val = '0;
        end else if (wr_en && (wr_addr == addr)) begin
            val = wr_data;
        end else begin
            val = mem_q[addr];
        end
        return val;
    endfunction

    // Next-state of the storage array
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr != 5'd0)) begin
            mem_d[wr_addr] = wr_data;
        end else begin
            mem_d = mem_q;
        end
        mem_d[0] = '0;
    end

    // Storage array with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports
    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage ahead of the 64-bit ALU: decode, busy-bit scoreboard,
// hazard stall and the registered {instruction, in1, in2} handoff.
module operand_fetch
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [63:0]     in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_in1,
    output logic [XLEN-1:0] out_in2,
    output logic [4:0]      out_rd,
    output logic [63:0]     out_pc,
    output logic            out_illegal
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [4:0]      rd_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic            is_op_s;
    logic            is_imm_s;
    logic            illegal_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;
    logic [NREGS-1:0] wb_clr_s;
    logic [NREGS-1:0] eff_busy_s;
    logic            hazard_s;
    logic            accept_s;
    logic [31:0]     san_instr_s;

    logic [NREGS-1:0] busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic             out_illegal_q, out_illegal_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [XLEN-1:0]  out_in1_q, out_in1_d;
    logic [XLEN-1:0]  out_in2_q, out_in2_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic [63:0]      out_pc_q, out_pc_d;

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_s),
        .rs2_addr (rs2_s),
        .rs1_data (rs1_data_s),
        .rs2_data (rs2_data_s),
        .wr_en    (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // Field decode, hazard detection and handshake
    always_comb begin
        opcode_s  = in_instr[6:0];
        rd_s      = in_instr[11:7];
        funct3_s  = in_instr[14:12];
        rs1_s     = in_instr[19:15];
        rs2_s     = in_instr[24:20];
        is_op_s   = (opcode_s == OPC_OP);
        is_imm_s  = (opcode_s == OPC_OP_IMM);
        illegal_s = !(is_op_s || is_imm_s);

        // A register being written back this cycle is no longer a hazard.
        wb_clr_s   = wb_en ? (32'd1 << wb_rd) : 32'd0;
        eff_busy_s = busy_q & ~wb_clr_s;
        hazard_s   = !illegal_s &&
                     (eff_busy_s[rs1_s] || (is_op_s && eff_busy_s[rs2_s]) || eff_busy_s[rd_s]);

        in_ready = (!out_valid_q || out_ready) && !(in_valid && hazard_s);
        accept_s = in_valid && in_ready;
    end

    // The ALU reads funct7[5] as SUB/SRA, so OP-IMM keeps it only for SRLI/SRAI.
    always_comb begin
        san_instr_s = in_instr;
        if (is_imm_s) begin
            case (funct3_s)
                F3_SR:   san_instr_s[31:25] = {1'b0, in_instr[30], 5'b00000};
                default: san_instr_s[31:25] = 7'b0000000;
            endcase
        end else begin
            san_instr_s = in_instr;
        end
    end

    // Scoreboard next state: set on issue beats clear on writeback
    always_comb begin
        busy_d = busy_q & ~wb_clr_s;
        if (accept_s && !illegal_s && (rd_s != 5'd0)) begin
            busy_d = busy_d | (32'd1 << rd_s);
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Output register next state
    always_comb begin
        out_valid_d   = out_valid_q;
        out_illegal_d = out_illegal_q;
        out_instr_d   = out_instr_q;
        out_in1_d     = out_in1_q;
        out_in2_d     = out_in2_q;
        out_rd_d      = out_rd_q;
        out_pc_d      = out_pc_q;
        if (accept_s) begin
            out_valid_d   = 1'b1;
            out_illegal_d = illegal_s;
            out_instr_d   = san_instr_s;
            out_pc_d      = in_pc;
            // Illegal ops carry rd=0 so a downstream writeback cannot clear a live busy bit.
            out_rd_d      = illegal_s ? 5'd0 : rd_s;
            out_in1_d     = illegal_s ? '0 : rs1_data_s;
            if (illegal_s) begin
                out_in2_d = '0;
            end else if (is_imm_s) begin
                out_in2_d = sext_imm12(in_instr[31:20]);
            end else begin
                out_in2_d = rs2_data_s;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q        <= '0;
            out_valid_q   <= 1'b0;
            out_illegal_q <= 1'b0;
            out_instr_q   <= 32'd0;
            out_in1_q     <= '0;
            out_in2_q     <= '0;
            out_rd_q      <= 5'd0;
            out_pc_q      <= 64'd0;
        end else begin
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_illegal_q <= out_illegal_d;
            out_instr_q   <= out_instr_d;
            out_in1_q     <= out_in1_d;
            out_in2_q     <= out_in2_d;
            out_rd_q      <= out_rd_d;
            out_pc_q      <= out_pc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_illegal = out_illegal_q;
    assign out_instr   = out_instr_q;
    assign out_in1     = out_in1_q;
    assign out_in2     = out_in2_q;
    assign out_rd      = out_rd_q;
    assign out_pc      = out_pc_q;

endmodule
